// File: rtl/mem_resp_ram.sv
// Multi-cycle data-memory responder for the FU_mem request port.
// Fixed-latency RV32 byte/half/word load/store with sign/zero extension.
module mem_resp_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        we,
    input  logic [2:0]  bhw,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        stall,
    output logic        ack,
    output logic        err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int AB    = ADDR_WIDTH + 2;
    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_ACK
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            latch;

    logic            r_we;
    logic [2:0]      r_bhw;
    logic [AB-1:0]   r_addr;
    logic [31:0]     r_din;

    logic            a_we;
    logic [2:0]      a_bhw;
    logic [AB-1:0]   a_addr;
    logic [31:0]     a_din;
    logic [1:0]      lane;
    logic [ADDR_WIDTH-1:0] widx;

    logic            go_ack;
    logic            bad;
    logic [31:0]     rdata;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [31:0]     ld;
    logic [3:0]      wmask;
    logic [31:0]     wdata;
    logic            mem_we;
    logic            unused_addr;

    logic [31:0]     mem [DEPTH];

    assign unused_addr = ^addr[31:AB];

    // FSM: next state and counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cs) begin
                    latch = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = S_ACK;
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = CW'(LATENCY - 1);
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q == CW'(1)) begin
                    state_d = S_ACK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we   <= 1'b0;
            r_bhw  <= '0;
            r_addr <= '0;
            r_din  <= '0;
        end else if (latch) begin
            r_we   <= we;
            r_bhw  <= bhw;
            r_addr <= addr[AB-1:0];
            r_din  <= din;
        end
    end

    // With LATENCY=1 the access happens on the accept edge itself,
    // so the live request inputs are used instead of the latched copy.
    always_comb begin
        if (state_q == S_IDLE) begin
            a_we   = we;
            a_bhw  = bhw;
            a_addr = addr[AB-1:0];
            a_din  = din;
        end else begin
            a_we   = r_we;
            a_bhw  = r_bhw;
            a_addr = r_addr;
            a_din  = r_din;
        end
    end

    assign lane   = a_addr[1:0];
    assign widx   = a_addr[AB-1:2];
    assign go_ack = (state_d == S_ACK) && (state_q != S_ACK);

    always_comb begin
        bad = 1'b0;
        unique case (a_bhw)
            F_B:     bad = 1'b0;
            F_H:     bad = lane[0];
            F_W:     bad = |lane;
            F_BU:    bad = a_we;
            F_HU:    bad = a_we | lane[0];
            default: bad = 1'b1;
        endcase
    end

    assign rdata  = mem[widx];
    assign byte_v = rdata[{lane, 3'b000} +: 8];
    assign half_v = lane[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        ld = '0;
        unique case (a_bhw)
            F_B:     ld = {{24{byte_v[7]}}, byte_v};
            F_BU:    ld = {24'h0, byte_v};
            F_H:     ld = {{16{half_v[15]}}, half_v};
            F_HU:    ld = {16'h0, half_v};
            F_W:     ld = rdata;
            default: ld = '0;
        endcase
    end

    always_comb begin
        wmask = 4'b0000;
        wdata = a_din;
        unique case (a_bhw)
            F_B: begin
                wmask = 4'b0001 << lane;
                wdata = {4{a_din[7:0]}};
            end
            F_H: begin
                wmask = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{a_din[15:0]}};
            end
            F_W: begin
                wmask = 4'b1111;
                wdata = a_din;
            end
            default: begin
                wmask = 4'b0000;
                wdata = a_din;
            end
        endcase
    end

    // Store commits on the edge entering ACK; rst gates a dropped request.
    assign mem_we = rst && go_ack && a_we && !bad;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout <= '0;
            err  <= 1'b0;
        end else if (go_ack) begin
            err <= bad;
            if (bad) begin
                dout <= '0;
            end else if (!a_we) begin
                dout <= ld;
            end
        end
    end

    assign stall = (state_q == S_BUSY);
    assign ack   = (state_q == S_ACK);

endmodule

// File: tb/tb_mem_resp_ram.sv
// Bench for mem_resp_ram: byte-array model checked every cycle,
// plus directed transactions with hand-computed literal results.
module tb_mem_resp_ram;

    localparam int L  = 4;
    localparam int AW = 10;
    localparam int NB = 4 << AW;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cs  = 1'b0;
    logic        we  = 1'b0;
    logic [2:0]  bhw = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] din  = '0;
    logic [31:0] dout;
    logic        stall;
    logic        ack;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    mem_resp_ram #(.ADDR_WIDTH(AW), .LATENCY(L)) dut (
        .clk(clk), .rst(rst), .cs(cs), .we(we), .bhw(bhw),
        .addr(addr), .din(din), .dout(dout), .stall(stall),
        .ack(ack), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: byte-addressed memory and request timeline in edge counts
    logic [7:0]  mmem [NB];
    int          e = 0;
    int          acc = 0;
    bit          busy = 0;
    logic        pwe;
    logic [2:0]  pf;
    logic [31:0] pa, pd;
    logic        exp_stall = 0, exp_ack = 0, exp_err = 0;
    logic [31:0] exp_dout = '0;

    task automatic model_access();
        int a, n;
        bit bad;
        logic [31:0] v;
        a = int'(pa % NB);
        case (pf)
            3'd0:    bad = 0;
            3'd1:    bad = (a % 2) != 0;
            3'd2:    bad = (a % 4) != 0;
            3'd4:    bad = pwe;
            3'd5:    bad = pwe || ((a % 2) != 0);
            default: bad = 1;
        endcase
        n = (pf == 3'd2) ? 4 : ((pf == 3'd1 || pf == 3'd5) ? 2 : 1);
        if (bad) begin
            exp_err  = 1;
            exp_dout = 0;
        end else if (pwe) begin
            exp_err = 0;
            for (int i = 0; i < n; i++) mmem[a + i] = pd[8*i +: 8];
        end else begin
            exp_err = 0;
            v = 0;
            for (int i = 0; i < n; i++) v = v | (32'(mmem[a + i]) << (8 * i));
            if (pf == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
            if (pf == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
            exp_dout = v;
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy = 0;
            exp_stall = 0;
            exp_ack = 0;
            exp_err = 0;
            exp_dout = 0;
        end else begin
            e++;
            if (busy) begin
                if (e == acc + L - 1) model_access();
                if (e == acc + L) busy = 0;
            end else if (cs) begin
                busy = 1;
                acc = e;
                pwe = we;
                pf = bhw;
                pa = addr;
                pd = din;
            end
            exp_stall = busy && (e < acc + L - 1);
            exp_ack   = busy && (e == acc + L - 1);
        end
    end

    always @(negedge clk) begin
        chk("stall", 32'(stall), 32'(exp_stall));
        chk("ack", 32'(ack), 32'(exp_ack));
        chk("dout", dout, exp_dout);
        if (exp_ack) chk("err", 32'(err), 32'(exp_err));
    end

    logic [31:0] r;
    logic        re;
    int          ns, ac;

    task automatic req(input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d,
                       input bit keep);
        bit got;
        cs = 1;
        we = w;
        bhw = f;
        addr = a;
        din = d;
        ns = 0;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (stall) ns++;
            if (ack) begin
                got = 1;
                r = dout;
                re = err;
                ac = cyc;
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got no ack expected ack within 20 cycles");
        end
        if (!keep) cs = 0;
    endtask

    task automatic lit(input string nm, input logic [31:0] v,
                       input logic ev);
        chk(nm, r, v);
        chk({nm, "_err"}, 32'(re), 32'(ev));
        chk({nm, "_model"}, exp_dout, v);
    endtask

    int a1, a2, a3;

    initial begin
        for (int i = 0; i < NB; i++) mmem[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_dout", dout, 0);
        rst = 1;
        @(negedge clk);

        req(1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
        chk("sw_err", 32'(re), 0);
        chk("sw_stall_cycles", 32'(ns), 32'(L - 1));
        req(0, 3'd2, 32'h10, 0, 0);
        lit("lw_10", 32'hDEADBEEF, 0);

        req(1, 3'd0, 32'h11, 32'h000000A5, 0);
        chk("sb_keeps_dout", r, 32'hDEADBEEF);
        req(0, 3'd2, 32'h10, 0, 0);
        lit("lw_after_sb", 32'hDEADA5EF, 0);
        req(0, 3'd0, 32'h11, 0, 0);
        lit("lb_11", 32'hFFFFFFA5, 0);
        req(0, 3'd4, 32'h11, 0, 0);
        lit("lbu_11", 32'h000000A5, 0);

        req(0, 3'd1, 32'h12, 0, 0);
        lit("lh_12", 32'hFFFFDEAD, 0);
        req(0, 3'd5, 32'h12, 0, 0);
        lit("lhu_12", 32'h0000DEAD, 0);
        req(0, 3'd1, 32'h11, 0, 0);
        lit("lh_mis", 32'h0, 1);
        req(1, 3'd2, 32'h13, 32'h55555555, 0);
        chk("sw_mis_err", 32'(re), 1);
        req(0, 3'd3, 32'h10, 0, 0);
        lit("bad_f3", 32'h0, 1);
        req(1, 3'd4, 32'h10, 32'h77, 0);
        chk("sbu_err", 32'(re), 1);
        req(0, 3'd2, 32'h10, 0, 0);
        lit("lw_unchanged", 32'hDEADA5EF, 0);
        req(1, 3'd1, 32'h12, 32'hFFFF1234, 0);
        req(0, 3'd2, 32'h10, 0, 0);
        lit("lw_after_sh", 32'h1234A5EF, 0);

        req(0, 3'd2, 32'h10, 0, 1);
        a1 = ac;
        req(0, 3'd2, 32'h10, 0, 1);
        a2 = ac;
        req(0, 3'd2, 32'h10, 0, 0);
        a3 = ac;
        chk("b2b_gap1", 32'(a2 - a1), 32'(L + 1));
        chk("b2b_gap2", 32'(a3 - a2), 32'(L + 1));

        req(1, 3'd2, 32'h20, 32'h11112222, 0);
        cs = 1;
        we = 1;
        bhw = 3'd2;
        addr = 32'h20;
        din = 32'h12345678;
        repeat (2) @(negedge clk);
        cs = 0;
        chk("pre_rst_stall", 32'(stall), 1);
        #2 rst = 0;
        #1;
        chk("rst_stall_drop", 32'(stall), 0);
        chk("rst_ack_drop", 32'(ack), 0);
        chk("rst_dout_clr", dout, 0);
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        req(0, 3'd2, 32'h20, 0, 0);
        lit("lw_after_rst", 32'h11112222, 0);

        req(1, 3'd2, 32'h1004, 32'hCAFEF00D, 0);
        req(0, 3'd2, 32'h004, 0, 0);
        lit("lw_wrap", 32'hCAFEF00D, 0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
